// File: rtl/turfio_cout_surf_tx.sv
// SURF->TURFIO COUT transmit framer: 32-bit words out as 4-bit nibbles, MSB nibble first.
module turfio_cout_surf_tx #(
    parameter logic [31:0] TRAIN_PATTERN = 32'hA55A6996,
    parameter logic [31:0] IDLE_WORD     = 32'h00000000
) (
    input  logic        rxclk_i,
    input  logic        rst_i,
    input  logic        enable_i,
    input  logic        train_i,
    input  logic [31:0] data_i,
    input  logic        data_valid_i,
    output logic        data_ready_o,
    output logic [3:0]  cout_o,
    output logic        word_start_o,
    output logic [1:0]  state_o,
    output logic [15:0] words_sent_o
);

    localparam int unsigned WORD_W = 32;
    localparam int unsigned NIB_W  = 4;
    localparam int unsigned CNT_W  = 3;
    localparam int unsigned WCNT_W = 16;

    typedef enum logic [1:0] {
        ST_OFF   = 2'b00,
        ST_TRAIN = 2'b01,
        ST_RUN   = 2'b10
    } state_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [WORD_W-1:0]   word_q, word_d;
    logic [NIB_W-1:0]    cout_q, cout_d;
    logic                ws_q, ws_d;
    logic [WCNT_W-1:0]   words_q, words_d;
    logic [CNT_W-1:0]    nxt_idx;
    logic                load_c;
    logic                xfer_c;

    // Word boundary: first cycle after enable from OFF, or last nibble of a word
    assign load_c       = enable_i && ((state_q == ST_OFF) || (cnt_q == 3'd7));
    assign data_ready_o = load_c && !train_i && !rst_i;
    assign xfer_c       = data_ready_o && data_valid_i;

    // Next-state, word load and nibble selection
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        word_d  = word_q;
        cout_d  = 4'hF;
        ws_d    = 1'b0;
        words_d = words_q + {15'd0, xfer_c};
        nxt_idx = cnt_q + 3'd1;
        if (!enable_i) begin
            // Disable aborts the in-flight word; line idles at all-ones
            state_d = ST_OFF;
            cnt_d   = '0;
        end else if (load_c) begin
            state_d = train_i ? ST_TRAIN : ST_RUN;
            if (train_i)
                word_d = TRAIN_PATTERN;
            else if (data_valid_i)
                word_d = data_i;
            else
                word_d = IDLE_WORD;
            cnt_d  = '0;
            cout_d = word_d[31:28];
            ws_d   = 1'b1;
        end else begin
            // Nibble k sits at bits 31-4k; {~k,2'b11} is that index for a 3-bit k
            cnt_d  = nxt_idx;
            cout_d = word_q[{~nxt_idx, 2'b11} -: 4];
        end
    end

    // State and output registers
    always_ff @(posedge rxclk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= ST_OFF;
            cnt_q   <= '0;
            word_q  <= IDLE_WORD;
            cout_q  <= 4'hF;
            ws_q    <= 1'b0;
            words_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            word_q  <= word_d;
            cout_q  <= cout_d;
            ws_q    <= ws_d;
            words_q <= words_d;
        end
    end

    assign cout_o       = cout_q;
    assign word_start_o = ws_q;
    assign state_o      = state_q;
    assign words_sent_o = words_q;

endmodule

// File: tb/tb_turfio_cout_surf_tx.sv
// Directed table-driven bench for turfio_cout_surf_tx.
module tb_turfio_cout_surf_tx;

    logic        clk = 1'b0;
    logic        rst;
    logic        enable;
    logic        train;
    logic [31:0] data;
    logic        valid;
    logic        ready;
    logic [3:0]  cout;
    logic        ws;
    logic [1:0]  st;
    logic [15:0] words;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        en;
        logic        tr;
        logic        v;
        logic [31:0] d;
        logic        rdy;
        logic [3:0]  cout;
        logic        ws;
        logic [1:0]  st;
        logic [15:0] words;
    } vec_t;

    vec_t vecs[$];

    turfio_cout_surf_tx dut (
        .rxclk_i      (clk),
        .rst_i        (rst),
        .enable_i     (enable),
        .train_i      (train),
        .data_i       (data),
        .data_valid_i (valid),
        .data_ready_o (ready),
        .cout_o       (cout),
        .word_start_o (ws),
        .state_o      (st),
        .words_sent_o (words)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int idx, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s step %0d: got %h want %h", name, idx, got, exp);
        end
    endtask

    // Drive inputs at negedge, check ready before the edge and registered outputs after it
    task automatic step(input int idx, input logic en, input logic tr, input logic v, input logic [31:0] d,
                        input logic e_rdy, input logic [3:0] e_cout, input logic e_ws,
                        input logic [1:0] e_st, input logic [15:0] e_words);
        @(negedge clk);
        enable = en; train = tr; valid = v; data = d;
        #1;
        check("ready", idx, 32'(ready), 32'(e_rdy));
        @(posedge clk);
        #1;
        check("cout", idx, 32'(cout), 32'(e_cout));
        check("word_start", idx, 32'(ws), 32'(e_ws));
        check("state", idx, 32'(st), 32'(e_st));
        check("words_sent", idx, 32'(words), 32'(e_words));
    endtask

    task automatic push(input logic en, input logic tr, input logic v, input logic [31:0] d,
                        input logic rdy, input logic [3:0] c, input logic w, input logic [1:0] s,
                        input logic [15:0] n);
        vec_t r;
        r.en = en; r.tr = tr; r.v = v; r.d = d;
        r.rdy = rdy; r.cout = c; r.ws = w; r.st = s; r.words = n;
        vecs.push_back(r);
    endtask

    // Eight rows of one word; inputs switch to the *_m set from the cnt==3 cycle onward
    task automatic push_word(input logic tr0, input logic v0, input logic [31:0] d0,
                             input logic trm, input logic vm, input logic [31:0] dm,
                             input logic [31:0] exp_word, input logic rdy0,
                             input logic [1:0] s, input logic [15:0] n);
        for (int j = 0; j < 8; j++) begin
            if (j < 4)
                push(1'b1, tr0, v0, d0, (j == 0) ? rdy0 : 1'b0,
                     4'(exp_word >> (28 - 4 * j)), (j == 0), s, n);
            else
                push(1'b1, trm, vm, dm, 1'b0, 4'(exp_word >> (28 - 4 * j)), 1'b0, s, n);
        end
    endtask

    initial begin
        rst = 1'b1; enable = 1'b0; train = 1'b0; valid = 1'b0; data = '0;

        // Idle OFF, then three training words (mode switch in the third), data, idle fill
        push(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 4'hF, 1'b0, 2'b00, 16'd0);
        push(1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 4'hF, 1'b0, 2'b00, 16'd0);
        push_word(1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 32'hA55A6996, 1'b0, 2'b01, 16'd0);
        push_word(1'b1, 1'b1, 32'h12345678, 1'b1, 1'b1, 32'h12345678, 32'hA55A6996, 1'b0, 2'b01, 16'd0);
        push_word(1'b1, 1'b0, 32'h0, 1'b0, 1'b1, 32'h12345678, 32'hA55A6996, 1'b0, 2'b01, 16'd0);
        push_word(1'b0, 1'b1, 32'h12345678, 1'b0, 1'b1, 32'hDEADBEEF, 32'h12345678, 1'b1, 2'b10, 16'd1);
        push_word(1'b0, 1'b1, 32'hDEADBEEF, 1'b0, 1'b0, 32'h0, 32'hDEADBEEF, 1'b1, 2'b10, 16'd2);
        push_word(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 32'hCAFEF00D, 32'h00000000, 1'b1, 2'b10, 16'd2);
        push_word(1'b0, 1'b1, 32'hCAFEF00D, 1'b0, 1'b0, 32'h0, 32'hCAFEF00D, 1'b1, 2'b10, 16'd3);

        // Reset values
        @(negedge clk);
        @(negedge clk);
        check("rst_cout", 0, 32'(cout), 32'hF);
        check("rst_ws", 0, 32'(ws), 32'h0);
        check("rst_state", 0, 32'(st), 32'h0);
        check("rst_words", 0, 32'(words), 32'h0);
        check("rst_ready", 0, 32'(ready), 32'h0);
        rst = 1'b0;

        foreach (vecs[i])
            step(i, vecs[i].en, vecs[i].tr, vecs[i].v, vecs[i].d,
                 vecs[i].rdy, vecs[i].cout, vecs[i].ws, vecs[i].st, vecs[i].words);

        // Abort at cnt==4: next cycle all-ones and OFF, count keeps the accepted word
        step(1000, 1'b1, 1'b0, 1'b1, 32'h13579BDF, 1'b1, 4'h1, 1'b1, 2'b10, 16'd4);
        step(1001, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 4'h3, 1'b0, 2'b10, 16'd4);
        step(1002, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 4'h5, 1'b0, 2'b10, 16'd4);
        step(1003, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 4'h7, 1'b0, 2'b10, 16'd4);
        step(1004, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 4'h9, 1'b0, 2'b10, 16'd4);
        step(1005, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 4'hF, 1'b0, 2'b00, 16'd4);
        step(1006, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 4'hF, 1'b0, 2'b00, 16'd4);

        // Counter wrap: preload 65535 transfers, send one more
        @(negedge clk);
        force dut.words_q = 16'hFFFF;
        #1;
        release dut.words_q;
        step(1100, 1'b1, 1'b0, 1'b1, 32'h0F0F0F0F, 1'b1, 4'h0, 1'b1, 2'b10, 16'd0);
        for (int k = 1; k < 8; k++)
            step(1100 + k, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, (k % 2 == 1) ? 4'hF : 4'h0, 1'b0, 2'b10, 16'd0);

        // Enable falls exactly at cnt==7: no load, no ready, OFF next
        step(1200, 1'b0, 1'b0, 1'b1, 32'h11111111, 1'b0, 4'hF, 1'b0, 2'b00, 16'd0);

        // Reset mid-word in RUN with enable still high
        step(1300, 1'b1, 1'b0, 1'b1, 32'h89ABCDEF, 1'b1, 4'h8, 1'b1, 2'b10, 16'd1);
        step(1301, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 4'h9, 1'b0, 2'b10, 16'd1);
        step(1302, 1'b1, 1'b0, 1'b1, 32'h22222222, 1'b0, 4'hA, 1'b0, 2'b10, 16'd1);
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("arst_cout", 1400, 32'(cout), 32'hF);
        check("arst_state", 1400, 32'(st), 32'h0);
        check("arst_words", 1400, 32'(words), 32'h0);
        check("arst_ws", 1400, 32'(ws), 32'h0);
        check("arst_ready", 1400, 32'(ready), 32'h0);
        @(negedge clk);
        enable = 1'b0;
        rst = 1'b0;
        for (int k = 0; k < 10; k++)
            step(1500 + k, 1'b0, 1'b0, 1'b1, 32'h33333333, 1'b0, 4'hF, 1'b0, 2'b00, 16'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
